cv32e40p_ft_block_manager: RTL and testbench
============================================

// Module: cv32e40p_ft_block_manager
// PURPOSE
//  Supervises one TMR voter group. Per-replica leaky error counters track mismatch reports.
//  A replica whose count reaches THRESHOLD is flagged broken; the flag drives the voters' broken_block_i.
//  A req/ack/done resync of that replica is then sequenced.
//  Uncorrectable or double faults escalate to a sticky fatal_o.
// PARAMETERS
//  CNT_W        3   width of each per-replica error counter (saturating)
//  THRESHOLD    4   count at which a replica is declared broken (1..2**CNT_W-1)
//  DECAY_PERIOD 64  error-free cycles per decrement of a nonzero counter; 0 = no decay
//  MAX_RESYNC   2   resyncs allowed per replica before it is permanently broken
// PORTS
//  clk             in   1          core clock
//  rst_n           in   1          asynchronous active-low reset
//  vote_valid_i    in   1          voter outputs below are meaningful this cycle
//  block_err_i     in   3          per-replica mismatch from the voter group
//  err_detected_i  in   1          voter group detected an error
//  err_corrected_i in   1          voter group corrected that error
//  broken_block_o  out  3          one-hot broken replica; feeds broken_block_i
//  resync_req_o    out  3          one-hot resync request, held until acknowledged
//  resync_ack_i    in   1          resync engine accepted the request
//  resync_done_i   in   1          resync complete (1-cycle pulse)
//  fatal_clr_i     in   1          software clear of the FATAL state
//  fatal_o         out  1          uncorrectable condition; sticky
//  state_o         out  3          ft_mgr_state_e encoding
//  err_cnt_o       out  3xCNT_W    per-replica counter values
// BEHAVIOUR
//  Reset: all outputs, counters, decay timers and resync counts are 0; state NORMAL.
//   Reset is honoured mid-handshake; the resync engine must abort on reset.
//  Counter k, active only when vote_valid_i & block_err_i[k]:
//   - increments, saturating at 2**CNT_W-1, and restarts decay timer k;
//   - is frozen while replica k is flagged broken.
//  Decay: when timer k reaches DECAY_PERIOD-1 and cnt[k]>0, decrement and restart the timer.
//   An increment in the same cycle wins and no decrement occurs.
//  Trip: the comparison uses the next-count value. The trip is registered, so
//   broken_block_o and resync_req_o assert the cycle after the tripping strobe (latency 1).
//  Fatal triggers, highest priority, accepted in any state with vote_valid_i:
//   - err_detected_i & ~err_corrected_i;
//   - more than one bit set in block_err_i.
//  Also fatal: two replicas trip in the same cycle, or a second replica trips while one is broken.
//  FSM (ft_mgr_state_e):
//   NORMAL : trip on k -> if rsync_cnt[k]<MAX_RESYNC then REQ, else PERM.
//            Both set broken_block_o=1<<k; REQ also sets resync_req_o=1<<k.
//   REQ    : hold resync_req_o. Then:
//            ack & done in the same cycle -> recover directly to NORMAL;
//            ack only -> WAIT, and resync_req_o deasserts the next cycle.
//   WAIT   : on resync_done_i, recover -> NORMAL.
//            Recover: clear cnt[k], timer[k] and broken_block_o; rsync_cnt[k]++.
//   PERM   : broken_block_o held forever; no request is issued.
//   FATAL  : fatal_o=1; broken_block_o and resync_req_o hold their values; counters frozen.
//            On fatal_clr_i -> NORMAL, clearing counters, timers, broken, req and rsync_cnt.
//            A fatal trigger in the same cycle as fatal_clr_i keeps the FSM in FATAL.
//  resync_ack_i and resync_done_i are ignored outside REQ/WAIT. resync_done_i in REQ without ack is ignored.
// STRUCTURE
//  ft_pkg: typedef enum logic[2:0] ft_mgr_state_e {FT_NORMAL,FT_REQ,FT_WAIT,FT_PERM,FT_FATAL};
//   plus a onehot3/popcount3 helper function.
//  Sub-module cv32e40p_ft_err_counter, instantiated 3x: saturating leaky counter + decay timer.
//   Inputs: inc, freeze, clr. Outputs: cnt, next_cnt.
//  The top level holds the FSM, trip/fatal logic and the rsync_cnt registers.
// TESTING (CNT_W=3, THRESHOLD=4, DECAY_PERIOD=8, MAX_RESYNC=2)
//  - 4 strobes block_err=3'b010 back-to-back -> cycle after the 4th: broken_block_o=3'b010,
//    resync_req_o=3'b010, state=REQ.
//  - REQ, ack at t, done at t+3 -> req low from t+1; state NORMAL at t+4; err_cnt_o[1]=0.
//  - 3 errors on replica 0, then 8 idle cycles -> cnt0 2; one error on the 8th idle cycle
//    -> cnt0=4 and a trip.
//  - Trip replica 2 three times with full resync each time -> 3rd trip gives PERM;
//    broken_block_o=3'b100 persists; resync_req_o stays 0.
//  - vote_valid with err_detected=1, err_corrected=0 (or block_err=3'b011) -> fatal_o=1 next
//    cycle; fatal_clr_i -> NORMAL, all counters 0.
//  - Assert rst_n=0 asynchronously in WAIT -> all outputs 0 immediately, state NORMAL.

Source files
------------

// File: rtl/ft_pkg.sv
// Shared types and helpers for the fault-tolerance block manager.
package ft_pkg;

  // Manager state; the encoding is exported on state_o.
  typedef enum logic [2:0] {
    FT_NORMAL = 3'd0,
    FT_REQ    = 3'd1,
    FT_WAIT   = 3'd2,
    FT_PERM   = 3'd3,
    FT_FATAL  = 3'd4
  } ft_mgr_state_e;

  localparam int NUM_REPLICAS = 3;

  // Number of set bits in a 3-bit vector.
  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/cv32e40p_ft_err_counter.sv
// Saturating leaky error counter for one replica, with its decay timer.
// next_cnt is the value the counter takes at the next edge; the manager
// uses it so a trip is decided in the same cycle as the tripping strobe.
module cv32e40p_ft_err_counter #(
  parameter int CNT_W        = 3,
  parameter int DECAY_PERIOD = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             freeze,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] next_cnt
);

  localparam int TW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [TW-1:0]    DECAY_LAST = (DECAY_PERIOD > 0) ? TW'(DECAY_PERIOD - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [TW-1:0] timer;
  logic [TW-1:0] next_timer;
  logic          decay_hit;

  // A period of 0 disables decay entirely.
  assign decay_hit = (DECAY_PERIOD > 0) && (cnt != '0) && (timer == DECAY_LAST);

  // Next counter/timer: clear beats freeze, increment beats decay.
  always_comb begin
    next_cnt   = cnt;
    next_timer = timer;
    if (clr) begin
      next_cnt   = '0;
      next_timer = '0;
    end else if (!freeze) begin
      if (inc) begin
        next_cnt   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        next_timer = '0;
      end else if (decay_hit) begin
        next_cnt   = cnt - 1'b1;
        next_timer = '0;
      end else if (cnt == '0) begin
        next_timer = '0;
      end else begin
        next_timer = timer + 1'b1;
      end
    end
  end

  // Counter and timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      timer <= '0;
    end else begin
      cnt   <= next_cnt;
      timer <= next_timer;
    end
  end

endmodule

// File: rtl/cv32e40p_ft_block_manager.sv
// Supervises one TMR voter group: counts per-replica mismatches, flags a
// replica broken when its count reaches THRESHOLD, sequences its resync and
// escalates uncorrectable or multi-replica faults to a sticky fatal state.
//
// Resync handshake: resync_req_o is a one-hot level raised together with
// broken_block_o and held until resync_ack_i is seen in REQ. resync_done_i
// is a single-cycle completion pulse accepted in WAIT, or in REQ only when
// it coincides with resync_ack_i. Both inputs are ignored in other states.
module cv32e40p_ft_block_manager
  import ft_pkg::*;
#(
  parameter int CNT_W        = 3,
  parameter int THRESHOLD    = 4,
  parameter int DECAY_PERIOD = 64,
  parameter int MAX_RESYNC   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vote_valid_i,
  input  logic [2:0]         block_err_i,
  input  logic               err_detected_i,
  input  logic               err_corrected_i,
  output logic [2:0]         broken_block_o,
  output logic [2:0]         resync_req_o,
  input  logic               resync_ack_i,
  input  logic               resync_done_i,
  input  logic               fatal_clr_i,
  output logic               fatal_o,
  output logic [2:0]         state_o,
  output logic [3*CNT_W-1:0] err_cnt_o
);

  localparam int RW = (MAX_RESYNC > 0) ? $clog2(MAX_RESYNC + 1) : 1;

  ft_mgr_state_e    state;
  logic [2:0]       broken;
  logic [2:0]       req;
  logic [RW-1:0]    rsync_cnt [NUM_REPLICAS];
  logic [CNT_W-1:0] cnt       [NUM_REPLICAS];
  logic [CNT_W-1:0] next_cnt  [NUM_REPLICAS];

  logic [2:0] inc, freeze, clr, trip, below_max;
  logic       in_fatal, fatal_trig, recover, clear_all;

  assign in_fatal = (state == FT_FATAL);

  for (genvar k = 0; k < NUM_REPLICAS; k++) begin : g_rep
    assign inc[k]       = vote_valid_i & block_err_i[k];
    assign freeze[k]    = in_fatal | broken[k];
    assign clr[k]       = clear_all | (recover & broken[k]);
    assign trip[k]      = inc[k] & ~freeze[k] & (next_cnt[k] >= CNT_W'(THRESHOLD));
    assign below_max[k] = (rsync_cnt[k] < RW'(MAX_RESYNC));

    cv32e40p_ft_err_counter #(
      .CNT_W       (CNT_W),
      .DECAY_PERIOD(DECAY_PERIOD)
    ) u_err_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (inc[k]),
      .freeze  (freeze[k]),
      .clr     (clr[k]),
      .cnt     (cnt[k]),
      .next_cnt(next_cnt[k])
    );

    assign err_cnt_o[k*CNT_W +: CNT_W] = cnt[k];
  end

  // Fatal has priority over every other transition, including clear and recover.
  assign fatal_trig = (vote_valid_i & ((err_detected_i & ~err_corrected_i) |
                                       (popcount3(block_err_i) > 2'd1)))
                    | (popcount3(trip) > 2'd1)
                    | ((|trip) & (|broken));
  assign recover    = ~fatal_trig & (((state == FT_REQ) & resync_ack_i & resync_done_i) |
                                     ((state == FT_WAIT) & resync_done_i));
  assign clear_all  = in_fatal & fatal_clr_i & ~fatal_trig;

  // Manager FSM with broken/request flags and per-replica resync counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FT_NORMAL;
      broken <= '0;
      req    <= '0;
      for (int k = 0; k < NUM_REPLICAS; k++) rsync_cnt[k] <= '0;
    end else if (fatal_trig) begin
      state <= FT_FATAL;
    end else if (recover) begin
      state  <= FT_NORMAL;
      broken <= '0;
      req    <= '0;
      for (int k = 0; k < NUM_REPLICAS; k++)
        if (broken[k]) rsync_cnt[k] <= rsync_cnt[k] + 1'b1;
    end else if (clear_all) begin
      state  <= FT_NORMAL;
      broken <= '0;
      req    <= '0;
      for (int k = 0; k < NUM_REPLICAS; k++) rsync_cnt[k] <= '0;
    end else begin
      case (state)
        FT_NORMAL: begin
          if (|trip) begin
            broken <= trip;
            if (|(trip & below_max)) begin
              req   <= trip;
              state <= FT_REQ;
            end else begin
              state <= FT_PERM;
            end
          end
        end
        FT_REQ: begin
          if (resync_ack_i) begin
            req   <= '0;
            state <= FT_WAIT;
          end
        end
        FT_WAIT, FT_PERM, FT_FATAL: ;
        default: state <= FT_NORMAL;
      endcase
    end
  end

  assign broken_block_o = broken;
  assign resync_req_o   = req;
  assign fatal_o        = in_fatal;
  assign state_o        = state;

endmodule

// File: tb/tb_cv32e40p_ft_block_manager.sv
// Bench for cv32e40p_ft_block_manager: directed scenarios plus a random
// phase, with a cycle-level reference model feeding an expected queue.
module tb_cv32e40p_ft_block_manager;

  localparam int CNT_W        = 3;
  localparam int THRESHOLD    = 4;
  localparam int DECAY_PERIOD = 8;
  localparam int MAX_RESYNC   = 2;
  localparam int CNT_SAT      = 7;
  localparam int SNAP_W       = 19;

  localparam int S_NORMAL = 0, S_REQ = 1, S_WAIT = 2, S_PERM = 3, S_FATAL = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               vote_valid = 1'b0;
  logic [2:0]         block_err = '0;
  logic               err_detected = 1'b0;
  logic               err_corrected = 1'b0;
  logic [2:0]         broken_block;
  logic [2:0]         resync_req;
  logic               resync_ack = 1'b0;
  logic               resync_done = 1'b0;
  logic               fatal_clr = 1'b0;
  logic               fatal;
  logic [2:0]         state;
  logic [3*CNT_W-1:0] err_cnt;

  // clock / reset
  always #5 clk = ~clk;

  cv32e40p_ft_block_manager #(
    .CNT_W       (CNT_W),
    .THRESHOLD   (THRESHOLD),
    .DECAY_PERIOD(DECAY_PERIOD),
    .MAX_RESYNC  (MAX_RESYNC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vote_valid_i   (vote_valid),
    .block_err_i    (block_err),
    .err_detected_i (err_detected),
    .err_corrected_i(err_corrected),
    .broken_block_o (broken_block),
    .resync_req_o   (resync_req),
    .resync_ack_i   (resync_ack),
    .resync_done_i  (resync_done),
    .fatal_clr_i    (fatal_clr),
    .fatal_o        (fatal),
    .state_o        (state),
    .err_cnt_o      (err_cnt)
  );

  int total = 0;
  int bad   = 0;
  logic [SNAP_W-1:0] exp_q[$];

  // reference model state
  int         m_state;
  int         m_cnt [3];
  int         m_tmr [3];
  int         m_rs  [3];
  logic [2:0] m_brk;
  logic [2:0] m_req;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_NORMAL;
    m_brk   = '0;
    m_req   = '0;
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0;
      m_tmr[k] = 0;
      m_rs[k]  = 0;
    end
  endtask

  task automatic model_step(input logic vv, input logic [2:0] be, input logic det, input logic cor,
                            input logic ack, input logic done, input logic clr);
    int ncnt [3];
    int ntmr [3];
    logic [2:0] trip;
    int ntrip;
    int nbe;
    bit fat;
    bit rec;
    ntrip = 0;
    nbe   = 0;
    trip  = '0;
    for (int k = 0; k < 3; k++) begin
      bit inc;
      bit frz;
      inc = vv && be[k];
      frz = (m_state == S_FATAL) || m_brk[k];
      ncnt[k] = m_cnt[k];
      ntmr[k] = m_tmr[k];
      if (!frz) begin
        if (inc) begin
          ncnt[k] = (m_cnt[k] == CNT_SAT) ? CNT_SAT : m_cnt[k] + 1;
          ntmr[k] = 0;
          trip[k] = (ncnt[k] >= THRESHOLD);
        end else if (m_cnt[k] > 0 && m_tmr[k] == DECAY_PERIOD - 1) begin
          ncnt[k] = m_cnt[k] - 1;
          ntmr[k] = 0;
        end else if (m_cnt[k] > 0) begin
          ntmr[k] = m_tmr[k] + 1;
        end else begin
          ntmr[k] = 0;
        end
      end
      if (trip[k]) ntrip++;
      if (be[k]) nbe++;
    end
    fat = (vv && ((det && !cor) || nbe > 1)) || ntrip > 1 || (ntrip > 0 && m_brk != 0);
    rec = 0;
    if (fat) begin
      m_state = S_FATAL;
    end else begin
      case (m_state)
        S_NORMAL: if (ntrip > 0) begin
          int idx;
          idx = trip[0] ? 0 : (trip[1] ? 1 : 2);
          m_brk = trip;
          if (m_rs[idx] < MAX_RESYNC) begin
            m_req   = trip;
            m_state = S_REQ;
          end else begin
            m_state = S_PERM;
          end
        end
        S_REQ: begin
          if (ack && done) rec = 1;
          else if (ack) begin
            m_req   = '0;
            m_state = S_WAIT;
          end
        end
        S_WAIT: if (done) rec = 1;
        S_FATAL: if (clr) begin
          m_state = S_NORMAL;
          m_brk   = '0;
          m_req   = '0;
          for (int k = 0; k < 3; k++) begin
            ncnt[k] = 0;
            ntmr[k] = 0;
            m_rs[k] = 0;
          end
        end
        default: ;
      endcase
    end
    if (rec) begin
      for (int k = 0; k < 3; k++)
        if (m_brk[k]) begin
          ncnt[k] = 0;
          ntmr[k] = 0;
          m_rs[k] = m_rs[k] + 1;
        end
      m_brk   = '0;
      m_req   = '0;
      m_state = S_NORMAL;
    end
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = ncnt[k];
      m_tmr[k] = ntmr[k];
    end
  endtask

  function automatic logic [SNAP_W-1:0] exp_snap();
    return {3'(m_state), m_brk, m_req, (m_state == S_FATAL),
            3'(m_cnt[2]), 3'(m_cnt[1]), 3'(m_cnt[0])};
  endfunction

  // scoreboard: pop one expected snapshot per clock and compare every output
  task automatic compare_out();
    logic [SNAP_W-1:0] e;
    e = exp_q.pop_front();
    check("state",   state,        e[18:16]);
    check("broken",  broken_block, e[15:13]);
    check("req",     resync_req,   e[12:10]);
    check("fatal",   fatal,        e[9]);
    check("err_cnt", err_cnt,      e[8:0]);
  endtask

  // driver: apply one cycle of inputs, predict, then sample after the edge
  task automatic drive(input logic vv, input logic [2:0] be, input logic det, input logic cor,
                       input logic ack, input logic done, input logic clr);
    @(negedge clk);
    vote_valid    = vv;
    block_err     = be;
    err_detected  = det;
    err_corrected = cor;
    resync_ack    = ack;
    resync_done   = done;
    fatal_clr     = clr;
    model_step(vv, be, det, cor, ack, done, clr);
    exp_q.push_back(exp_snap());
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic strobe(input logic [2:0] be, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, be, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #2;
    check("rst_state",  state,        3'd0);
    check("rst_broken", broken_block, 3'b000);
    check("rst_req",    resync_req,   3'b000);
    check("rst_fatal",  fatal,        1'b0);
    check("rst_cnt",    err_cnt,      9'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // four back-to-back strobes on replica 1 trip it
    strobe(3'b010, 4);
    check("trip1_broken", broken_block, 3'b010);
    check("trip1_req",    resync_req,   3'b010);
    check("trip1_state",  state,        3'd1);
    idle(1);
    check("req_held", resync_req, 3'b010);
    // ack at t, done at t+3
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("req_low_after_ack", resync_req, 3'b000);
    idle(2);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("recover_state", state, 3'd0);
    check("recover_cnt1",  err_cnt[5:3], 3'd0);

    // decay: 3 errors then 8 idle cycles leaves 2
    strobe(3'b001, 3);
    idle(8);
    check("decay_cnt0", err_cnt[2:0], 3'd2);
    strobe(3'b001, 1);
    idle(7);
    strobe(3'b001, 1);
    check("inc_beats_decay", err_cnt[2:0], 3'd4);
    check("trip0_broken",    broken_block, 3'b001);
    // ack and done together recover directly
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("direct_recover", state, 3'd0);

    // replica 2 exhausts its resyncs
    for (int t = 0; t < 3; t++) begin
      strobe(3'b100, 4);
      if (t == 0) begin
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end else if (t == 1) begin
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      end
    end
    check("perm_state",  state,        3'd3);
    check("perm_broken", broken_block, 3'b100);
    check("perm_req",    resync_req,   3'b000);
    for (int i = 0; i < 3; i++) drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("perm_persist", broken_block, 3'b100);

    // second replica tripping while one is broken is fatal
    strobe(3'b010, 4);
    check("second_trip_fatal", fatal, 1'b1);
    check("fatal_holds_brk",   broken_block, 3'b100);
    strobe(3'b001, 2);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_state", state,   3'd0);
    check("clr_cnt",   err_cnt, 9'd0);

    // uncorrected error, clear racing a new trigger, corrected error, multi-bit mismatch
    drive(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("uncorrected_fatal", fatal, 1'b1);
    drive(1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_vs_trigger", state, 3'd4);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("corrected_ok", fatal, 1'b0);
    drive(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("invalid_ignored", fatal, 1'b0);
    drive(1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("multibit_fatal", fatal, 1'b1);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // asynchronous reset while in WAIT
    strobe(3'b001, 4);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pre_reset_wait", state, 3'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state",  state,        3'd0);
    check("arst_broken", broken_block, 3'b000);
    check("arst_req",    resync_req,   3'b000);
    check("arst_fatal",  fatal,        1'b0);
    check("arst_cnt",    err_cnt,      9'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic vv, det, cor, ack, done, clr;
      logic [2:0] be;
      int sel;
      vv  = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 15);
      be  = (sel < 4) ? 3'b001 : (sel < 8) ? 3'b010 : (sel < 12) ? 3'b100 :
            (sel == 15) ? 3'(1 + $urandom_range(0, 6)) : 3'b000;
      det  = ($urandom_range(0, 7) == 0);
      cor  = det && ($urandom_range(0, 3) != 0);
      ack  = ($urandom_range(0, 3) == 0);
      done = ($urandom_range(0, 3) == 0);
      clr  = ($urandom_range(0, 7) == 0);
      drive(vv, be, det, cor, ack, done, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
